// File: rtl/cpu_seq.sv
// Multi-cycle sequencer for a small register-file/ALU datapath.
// It fetches 24-bit program words, decodes class and fields, and drives ALU and register-file control.
module cpu_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [23:0]           instr,
  input  logic [DATA_WIDTH-1:0] alu_y,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [7:0]            opcode,
  output logic [ADDR_WIDTH-1:0] ra_addr,
  output logic [ADDR_WIDTH-1:0] rb_addr,
  output logic [ADDR_WIDTH-1:0] wa_addr,
  output logic                  wr,
  output logic                  busy,
  output logic                  halted,
  output logic                  zero_flag,
  output logic                  illegal
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;

  state_t                state;
  logic [23:0]           ir;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic [ADDR_WIDTH-1:0] target;

  // Natural width wrap gives pc rollover from all-ones back to zero.
  assign pc_next = pc + ADDR_WIDTH'(1);
  assign target  = ADDR_WIDTH'(ir[3:0]);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      ir        <= '0;
      pc        <= '0;
      opcode    <= '0;
      ra_addr   <= '0;
      rb_addr   <= '0;
      wa_addr   <= '0;
      wr        <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      zero_flag <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      wr <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH;
            pc    <= '0;
            busy  <= 1'b1;
          end
        end
        FETCH: begin
          ir    <= instr;
          state <= DECODE;
        end
        DECODE: begin
          opcode  <= ir[23:16];
          ra_addr <= ADDR_WIDTH'(ir[7:4]);
          rb_addr <= ADDR_WIDTH'(ir[3:0]);
          case (ir[15:12])
            4'd0: begin
              pc    <= pc_next;
              state <= FETCH;
            end
            4'd1: state <= EXEC;
            4'd2: begin
              pc    <= target;
              state <= FETCH;
            end
            4'd3: begin
              pc    <= zero_flag ? target : pc_next;
              state <= FETCH;
            end
            4'd4: begin
              state  <= HALT;
              busy   <= 1'b0;
              halted <= 1'b1;
            end
            default: begin
              illegal <= 1'b1;
              pc      <= pc_next;
              state   <= FETCH;
            end
          endcase
        end
        // Write strobe and address are staged here so they appear exactly in the WB cycle.
        EXEC: begin
          zero_flag <= (alu_y == '0);
          wa_addr   <= ADDR_WIDTH'(ir[11:8]);
          wr        <= 1'b1;
          state     <= WB;
        end
        WB: begin
          pc    <= pc_next;
          state <= FETCH;
        end
        HALT: begin
          if (start) begin
            state  <= FETCH;
            pc     <= '0;
            busy   <= 1'b1;
            halted <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
